// File: rtl/axi4_lite_master_q.sv
// axi4_lite_master_q
//   Queued AXI4-Lite master. Read/write commands enter a CMD_DEPTH-deep FIFO
//   and are executed strictly in order, one bus transaction at a time. Each
//   command produces exactly one response on the response port.
//
// Handshake semantics (all valid/ready pairs, command, response and AXI):
//   A transfer happens on a rising aclk edge where valid && ready. The
//   producer holds valid high with a stable payload until that edge. It never
//   withdraws valid early. Ready may be raised or dropped freely.
//
// Ports
//   aclk, rst_n          clock, synchronous active-low reset
//   cmd_*                command input (valid/ready), cmd_ready = FIFO not full
//   rsp_*                response output (valid/ready), rdata is 0 for writes
//   busy                 FIFO non-empty or a transaction in progress
//   pending              FIFO occupancy, 0..CMD_DEPTH
//   aw*/w*/b*/ar*/r*     AXI4-Lite master channels, prot fixed to 3'b000
module axi4_lite_master_q #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4
) (
  input  logic                         aclk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic [DATA_W/8-1:0]          cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   pending,
  output logic [ADDR_W-1:0]            awaddr,
  output logic [2:0]                   awprot,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [DATA_W-1:0]            wdata,
  output logic [DATA_W/8-1:0]          wstrb,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready,
  output logic [ADDR_W-1:0]            araddr,
  output logic [2:0]                   arprot,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rvalid,
  output logic                         rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CMD_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RSP} state_e;

  state_e              state_q, state_d;
  logic [ENT_W-1:0]    mem_q [CMD_DEPTH];
  logic [ENT_W-1:0]    mem_d [CMD_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cur_write_q, cur_write_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0]   cur_wdata_q, cur_wdata_d;
  logic [STRB_W-1:0]   cur_wstrb_q, cur_wstrb_d;
  // launch_q marks the first cycle in WR/RA; the AXI valids rise one cycle
  // after the pop so the latched command is already stable on the bus.
  logic                launch_q, launch_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  logic                push, pop, aw_hs, w_hs;
  logic                head_write;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;
  logic [STRB_W-1:0]   head_wstrb;

  assign cmd_ready = (cnt_q != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);
  assign aw_hs     = awvalid_q && awready;
  assign w_hs      = wvalid_q && wready;
  assign {head_write, head_addr, head_wdata, head_wstrb} = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_write, cmd_addr, cmd_wdata, cmd_wstrb};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_write_d = cur_write_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    cur_wstrb_d = cur_wstrb_q;
    launch_d    = 1'b0;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_write_d = head_write;
          cur_addr_d  = head_addr;
          cur_wdata_d = head_wdata;
          cur_wstrb_d = head_wstrb;
          launch_d    = 1'b1;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          state_d     = head_write ? S_WR : S_RA;
        end
      end
      S_WR: begin
        if (launch_q) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          // AW and W complete independently, in any order or together.
          if (aw_hs) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
          if (w_hs) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_d = 1'b1;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        if (bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RA: begin
        if (launch_q) begin
          arvalid_d = 1'b1;
        end else if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        if (rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge aclk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cur_write_q <= 1'b0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      cur_wstrb_q <= '0;
      launch_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      cur_write_q <= cur_write_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      cur_wstrb_q <= cur_wstrb_d;
      launch_q    <= launch_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Payloads come straight from the latched command, which only changes on
  // a pop, so they are stable for the whole life of each valid.
  assign awaddr    = cur_addr_q;
  assign araddr    = cur_addr_q;
  assign wdata     = cur_wdata_q;
  assign wstrb     = cur_wstrb_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign busy      = (cnt_q != '0) || (state_q != S_IDLE);
  assign pending   = cnt_q;

endmodule

// File: tb/tb_axi4_lite_master_q.sv
// Testbench for axi4_lite_master_q: AXI4-Lite slave model with memory and
// configurable stalls, a reference model that predicts every response when
// the command is issued, and a response monitor that checks them in order.
module tb_axi4_lite_master_q;
  localparam int AW = 32, DW = 32, SW = 4, DEPTH = 4;
  localparam int EW = 1 + 2 + DW;

  logic          aclk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [2:0]    pending;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axi4_lite_master_q #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .pending(pending),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- clock ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0, n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   ref_mem [logic [31:0]];
  logic [31:0]   slv_mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address map of the slave: bits [13:12] = 01 -> SLVERR, 10 -> DECERR.
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    case (a[13:12])
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Reference model: commands run in order, so the response is fully known
  // at issue time from the memory contents left by earlier commands.
  task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0]  r = resp_of(a);
    logic [31:0] k = a >> 2;
    logic [31:0] old = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    if (w) begin
      if (r == 2'b00) ref_mem[k] = merge(old, d, s);
      exp_q.push_back({1'b1, r, 32'h0});
    end else begin
      exp_q.push_back({1'b0, r, (r != 2'b00) ? 32'h0BAD_0BAD : old});
    end
  endtask

  // ---------------- slave model ----------------
  int rdy_pct = 100;
  bit w_stall_mode = 0, b_block = 0;
  int w_hold = 0, b_count = 0, w_stall_seen = 0;
  bit have_aw, have_w, have_ar, f_aw, f_w, f_b, f_ar, f_r;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  bit          p_rst, p_awvalid, p_wvalid, p_arvalid;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  function automatic bit roll();
    return $urandom_range(0, 99) < rdy_pct;
  endfunction

  // Runs on the falling edge: the f_* flags record handshakes that the DUT
  // will see on the next rising edge; they are applied one falling edge later.
  always @(negedge aclk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      have_aw = 0; have_w = 0; have_ar = 0;
      f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0; w_hold = 0;
      p_rst = 1;
    end else begin
      if (!p_rst) begin
        if (p_awvalid) begin
          if (f_aw) check("aw_drop", awvalid, 0);
          else begin check("aw_hold", awvalid, 1); check("aw_stable", awaddr, p_awaddr); end
        end
        if (p_wvalid) begin
          if (f_w) check("w_drop", wvalid, 0);
          else begin check("w_hold", wvalid, 1); check("w_stable", {wstrb, wdata}, {p_wstrb, p_wdata}); end
        end
        if (p_arvalid) begin
          if (f_ar) check("ar_drop", arvalid, 0);
          else begin check("ar_hold", arvalid, 1); check("ar_stable", araddr, p_araddr); end
        end
        if (awvalid || arvalid) check("aw_ar_exclusive", awvalid && arvalid, 0);
      end
      if (f_b) bvalid = 0;
      if (f_r) rvalid = 0;
      awready = !have_aw && roll();
      if (w_stall_mode && (!have_aw || w_hold > 0)) begin
        wready = 0;
        if (have_aw) w_hold--;
      end else wready = !have_w && roll();
      if (have_aw && have_w && !bvalid && !b_block && roll()) begin
        bresp = resp_of(s_awaddr);
        if (bresp == 2'b00)
          slv_mem[s_awaddr >> 2] = merge(slv_mem.exists(s_awaddr >> 2) ? slv_mem[s_awaddr >> 2] : 32'h0, s_wdata, s_wstrb);
        bvalid = 1; have_aw = 0; have_w = 0;
      end
      arready = !have_ar && roll();
      if (have_ar && !rvalid && roll()) begin
        rresp = resp_of(s_araddr);
        rdata = (rresp != 2'b00) ? 32'h0BAD_0BAD :
                (slv_mem.exists(s_araddr >> 2) ? slv_mem[s_araddr >> 2] : 32'h0);
        rvalid = 1; have_ar = 0;
      end
      if (wvalid && !wready && !awvalid) w_stall_seen++;
      f_aw = awvalid && awready;
      if (f_aw) begin have_aw = 1; s_awaddr = awaddr; if (w_stall_mode) w_hold = 3; end
      f_w = wvalid && wready;
      if (f_w) begin have_w = 1; s_wdata = wdata; s_wstrb = wstrb; end
      f_ar = arvalid && arready;
      if (f_ar) begin have_ar = 1; s_araddr = araddr; end
      f_b = bvalid && bready;
      if (f_b) b_count++;
      f_r = rvalid && rready;
      p_awvalid = awvalid; p_wvalid = wvalid; p_arvalid = arvalid;
      p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
      p_rst = 0;
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  bit rsp_block = 0;
  int rsp_pct = 100;
  bit p_rv, p_rhs;
  logic [EW-1:0] p_rf;

  always @(negedge aclk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      rsp_ready = 0; p_rv = 0; p_rhs = 0;
    end else begin
      if (p_rv && !p_rhs) begin
        check("rsp_hold", rsp_valid, 1);
        check("rsp_stable", {rsp_write, rsp_resp, rsp_rdata}, p_rf);
      end
      rsp_ready = !rsp_block && ($urandom_range(0, 99) < rsp_pct);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rsp_unexpected: got write=%0d resp=%0d, expected no response", rsp_write, rsp_resp);
        end else begin
          e = exp_q.pop_front();
          check("rsp_write", rsp_write, e[34]);
          check("rsp_resp", rsp_resp, e[33:32]);
          check("rsp_rdata", rsp_rdata, e[31:0]);
        end
      end
      if (pending != 0) check("pending_le_depth", pending > 3'(DEPTH), 0);
      p_rv = rsp_valid; p_rhs = rsp_valid && rsp_ready;
      p_rf = {rsp_write, rsp_resp, rsp_rdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int g = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    while (!cmd_ready && g < 2000) begin @(negedge aclk); g++; end
    if (!cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready=0 after %0d cycles, expected 1", g);
      cmd_valid = 1'b0;
      return;
    end
    model_push(w, a, d, s);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 5000) begin @(negedge aclk); g++; end
    if (g >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, b0, g;
    logic w;
    logic [31:0] a, d;
    logic [3:0] s;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(negedge aclk);
    check("rst_axi_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_payloads", {awaddr, araddr, wdata, wstrb, awprot, arprot} == '0, 1);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy_pending", {busy, pending}, 0);
    rst_n = 1;
    @(negedge aclk);

    // Single write, zero-wait slave: valids rise two cycles after handshake.
    send(1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    lat = 0;
    while (!awvalid && lat < 20) begin @(negedge aclk); lat++; end
    check("aw_latency", lat, 2);
    check("w_with_aw", wvalid, 1);
    check("lat_awaddr", awaddr, 32'h10);
    check("lat_wdata", {wstrb, wdata}, {4'hF, 32'hDEAD_BEEF});
    drain();
    // Read back.
    send(0, 32'h10, 32'h5555_5555, 4'h0);
    drain();

    // W stalled for 3 cycles after the AW handshake; exactly one B.
    w_stall_mode = 1; w_stall_seen = 0; b0 = b_count;
    send(1, 32'h20, 32'h1234_5678, 4'b0101);
    drain();
    check("w_stall_cycles", w_stall_seen, 3);
    check("one_b", b_count - b0, 1);
    w_stall_mode = 0;
    send(0, 32'h20, 32'h0, 4'h0);
    drain();

    // Five back-to-back commands with responses blocked.
    rsp_block = 1;
    send(1, 32'h100, 32'hA1A1_A1A1, 4'hF);
    send(0, 32'h100, 32'h0, 4'h0);
    send(1, 32'h104, 32'hB2B2_B2B2, 4'h3);
    send(0, 32'h104, 32'h0, 4'h0);
    send(1, 32'h108, 32'hC3C3_C3C3, 4'hF);
    repeat (3) @(negedge aclk);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_pending", pending, 4);
    check("full_busy", busy, 1);
    rsp_block = 0;
    drain();

    // SLVERR on the middle write, then error reads.
    send(1, 32'h30, 32'h1111_1111, 4'hF);
    send(1, 32'h1010, 32'h2222_2222, 4'hF);
    send(1, 32'h34, 32'h3333_3333, 4'hF);
    send(0, 32'h1010, 32'h0, 4'h0);
    send(0, 32'h2000, 32'h0, 4'h0);
    send(0, 32'h34, 32'h0, 4'h0);
    drain();

    // Randomized traffic with random slave and consumer stalls.
    for (int bt = 0; bt < 4; bt++) begin
      rdy_pct = $urandom_range(40, 100);
      rsp_pct = $urandom_range(40, 100);
      for (int i = 0; i < 20; i++) begin
        w = 1'($urandom_range(0, 1));
        a = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2));
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        send(w, a, d, s);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge aclk);
      end
      drain();
    end
    rdy_pct = 100; rsp_pct = 100;

    // Reset while waiting for B with two commands queued.
    b_block = 1;
    send(1, 32'h300, 32'h0F0F_0F0F, 4'hF);
    send(1, 32'h304, 32'hF0F0_F0F0, 4'hF);
    send(0, 32'h308, 32'h0, 4'h0);
    g = 0;
    while (!(bready && pending == 2) && g < 100) begin @(negedge aclk); g++; end
    check("reached_wb", {bready, pending}, {1'b1, 3'd2});
    rst_n = 0;
    @(negedge aclk);
    check("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_mid_state", {pending, busy, rsp_valid, cmd_ready}, {3'd0, 1'b0, 1'b0, 1'b1});
    exp_q.delete();
    b_block = 0;
    @(negedge aclk);
    rst_n = 1;
    @(negedge aclk);

    // Recovery after reset.
    send(1, 32'h400, 32'h7654_3210, 4'b1100);
    send(0, 32'h400, 32'h0, 4'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
